alu_arbiter: RTL
================

# alu_arbiter

Shares the single datapath ALU between two requesters (req0 = main execute stage, req1 = auxiliary unit such as a branch-compare or address helper). Each requester uses a valid/ready handshake. A round-robin arbiter grants one accepted operation per cycle. A one-entry registered response slot returns the result tagged with the requester ID. Undefined op codes never reach the ALU; they complete with an error flag.

## Interface
Parameters:
- `FAIR`, default 1: 1 = round-robin between req0/req1; 0 = fixed priority, req0 always wins.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b` input 32 each: operands.
- `req0_op` input 4: ALU control code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as req0, for requester 1.
- `resp_valid` output 1: response slot holds a result.
- `resp_ready` input 1: consumer takes the result.
- `resp_id` output 1: requester that issued the result.
- `resp_data` output 32: ALU result.
- `resp_err` output 1: op code was undefined.

## Operation
- Legal op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^32)
  - 0110 SUB (wraps mod 2^32)
  - 0111 SLT (unsigned compare, result 1 or 0)
  - 1100 NOR
- Any other code: `resp_data` = 0, `resp_err` = 1, with normal latency and ID.
- Slot FSM has two states:
  - EMPTY: `resp_valid` = 0.
  - FULL: `resp_valid` = 1.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `resp_ready` with no new accept.
  - FULL→FULL on `resp_ready` with a simultaneous accept: the slot is overwritten with the new result.
- Slot is free when it is EMPTY, or when it is FULL and `resp_ready` = 1.
- `reqN_ready` = grant to N AND `reqN_valid` AND slot free. At most one ready per cycle.
- Grant rules:
  - Only one valid: that requester is granted.
  - Both valid, FAIR=1: grant goes to the requester not recorded in `last_grant`.
  - Both valid, FAIR=0: req0 is granted.
- `last_grant` updates only on an actual accept, not on a mere grant.
- Requesters must hold a, b, op stable while valid and not ready.
- When the slot is not free, no ready is asserted and the arbitration state holds.
- Response fields are stable while `resp_valid` = 1 and `resp_ready` = 0.

## Timing
- Reset values:
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `resp_err` = 0.
  - `last_grant` = 1, so req0 wins first.
  - `req0_ready` = `req1_ready` = 0 while `rst` is high.
- Latency: accept at edge N; `resp_valid`/`resp_data` visible after edge N, consumable at edge N+1.
- Throughput: 1 op/cycle while `resp_ready` stays high.
- `reqN_ready` is combinational from valid, slot state and `resp_ready`. It carries no combinational path from operands.
- Reset mid-operation: a held result is discarded and an in-flight accept is lost. Requesters re-issue after reset.

## Configuration
- `ALU_ARB_ZERO_EN` defined:
  - Adds output `resp_zero` (1 bit), registered with the slot. It is 1 when the result is all-zero and `resp_err` = 0.
  - Resets to 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `alu_arb_pkg` holds:
  - Op-code constants `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`, `OP_NOR`.
  - Legality function `op_legal`.
  - Slot-state enum `{ST_EMPTY, ST_FULL}`.
- Sub-module `alu_rr_arb2`: two-input round-robin grant logic with the `FAIR` parameter and an internal `last_grant` register.
- The top level instantiates `alu_rr_arb2` and the existing combinational `ALU`. The ALU `contr` input is driven with `OP_AND` whenever the muxed op is illegal.

## Test plan
- Reset, then req0 ADD a=5, b=7 with `resp_ready`=1 → `req0_ready` same cycle; next cycle `resp_valid`=1, `resp_data`=12, `resp_id`=0, `resp_err`=0.
- Both valid for 4 cycles, FAIR=1, `resp_ready`=1 → accept order 0,1,0,1; with FAIR=0 → 0,0,0,0.
- req1 SUB a=0, b=1 → `resp_data`=0xFFFFFFFF. SLT a=0xFFFFFFFF, b=1 → `resp_data`=0 (unsigned).
- `resp_ready`=0 with a result held, both requesters valid → both readies 0 for 3 cycles, response fields stable. Raise `resp_ready` → the held result is taken and a new accept happens the same cycle.
- req0 op=4'b1010 → `resp_err`=1, `resp_data`=0. With `ALU_ARB_ZERO_EN`: `resp_zero`=0; AND a=0xF0, b=0x0F → `resp_zero`=1.
- Assert `rst` mid-stream with `resp_valid`=1 → `resp_valid` drops asynchronously; after release, req0 wins the first tie.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, legality check,
// response-slot state and the packed request/response records.
package alu_arb_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {ST_EMPTY, ST_FULL} slot_st_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } alu_req_t;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] data;
  } resp_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter; master = requesters + consumer, slave = arbiter.
// resp_zero exists only when ALU_ARB_ZERO_EN is defined.
interface alu_arbiter_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_op;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_err;
`ifdef ALU_ARB_ZERO_EN
  logic        resp_zero;
`endif

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
`ifdef ALU_ARB_ZERO_EN
    input  resp_zero,
`endif
    input  resp_valid, resp_id, resp_data, resp_err,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
`ifdef ALU_ARB_ZERO_EN
    output resp_zero,
`endif
    output resp_valid, resp_id, resp_data, resp_err,
    input  resp_ready
  );

endinterface

// File: rtl/alu.sv
// Combinational datapath ALU selected by a 4-bit control code.
// Latency: zero (pure combinational). Backpressure: none, no handshake.
// Unknown control codes produce zero.
module ALU
  import alu_arb_pkg::*;
(
  input  logic [3:0]  contr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (contr)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_SLT: result = {31'b0, (a < b)};
      OP_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-input grant logic, round-robin (FAIR=1) or fixed priority to input 0 (FAIR=0).
// Latency: readies combinational from req/free; last_grant registered on accept.
// Backpressure: no ready while the slot is not free or reset is asserted.
module alu_rr_arb2 #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       free,
  output logic [1:0] rdy
);

  logic       last_grant;
  logic [1:0] gnt;

  // On a tie, the requester not served most recently wins; with FAIR=0 input 0 always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if ((FAIR != 0) && !last_grant) gnt = 2'b10;
      else                            gnt = 2'b01;
    end
    rdy = (free && !rst) ? gnt : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (|rdy)   last_grant <= rdy[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; result held in a one-entry slot.
// Latency: accept at edge N, response visible after N. Backpressure: no accept when slot full and resp_ready low.
// ALU_ARB_ZERO_EN adds a registered resp_zero flag.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  slot_st_t    state_q, state_d;
  logic        free;
  logic        accept;
  logic [1:0]  rdy;
  alu_req_t    req0, req1, sel;
  logic        legal;
  logic [3:0]  alu_op;
  logic [31:0] alu_y;
  resp_t       resp_d, resp_q;

  assign free   = (state_q == ST_EMPTY) || bus.resp_ready;
  assign accept = |rdy;

  alu_rr_arb2 #(.FAIR(FAIR)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({bus.req1_valid, bus.req0_valid}),
    .free (free),
    .rdy  (rdy)
  );

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];

  assign req0 = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op};
  assign req1 = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op};
  assign sel  = rdy[1] ? req1 : req0;

  // Illegal codes are steered to AND so the ALU only ever sees defined controls.
  assign legal  = op_legal(sel.op);
  assign alu_op = legal ? sel.op : OP_AND;

  ALU u_alu (
    .contr  (alu_op),
    .a      (sel.a),
    .b      (sel.b),
    .result (alu_y)
  );

  assign resp_d = '{id: rdy[1], err: !legal, data: (legal ? alu_y : 32'd0)};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)               state_d = ST_FULL;
        else if (bus.resp_ready)  state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         resp_q <= '0;
    else if (accept) resp_q <= resp_d;
  end

  assign bus.resp_valid = (state_q == ST_FULL);
  assign bus.resp_id    = resp_q.id;
  assign bus.resp_err   = resp_q.err;
  assign bus.resp_data  = resp_q.data;

`ifdef ALU_ARB_ZERO_EN
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         zero_q <= 1'b0;
    else if (accept) zero_q <= (resp_d.data == 32'd0) && !resp_d.err;
  end

  assign bus.resp_zero = zero_q;
`endif

endmodule
